// File: rtl/fm_streamer.sv
// fm_streamer: reads one feature map from a synchronous-read BRAM and streams
// it row-major to a PE input. Zero padding is inserted on the fly, o_en stays
// high for the whole padded map plus the flush slots, and o_done pulses in the
// cycle right after the final o_en beat.

module fm_streamer #(
   parameter int FM_SIZE      = 8,
   parameter int PADDING      = 0,
   parameter int DATA_WIDTH   = 30,
   parameter int FLUSH_CYCLES = 2,
   parameter int ADDR_WIDTH   = $clog2(FM_SIZE*FM_SIZE)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_rd_en,
   output logic [ADDR_WIDTH-1:0]        o_rd_addr,
   input  logic signed [DATA_WIDTH-1:0] i_rd_data,
   output logic                         o_en,
   output logic signed [DATA_WIDTH-1:0] o_data
);

   localparam int PS = FM_SIZE + 2*PADDING;
   localparam int CW = $clog2(PS + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 2);

   localparam logic [CW-1:0] LastPos  = CW'(PS - 1);
   localparam logic [FW-1:0] FlushEnd = FW'(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           row_q, row_d;
   logic [CW-1:0]           col_q, col_d;
   logic [ADDR_WIDTH-1:0]   nextAddr_q, nextAddr_d;
   logic [FW-1:0]           flushCnt_q, flushCnt_d;
   logic                    rdEn_q, rdEn_d;
   logic [ADDR_WIDTH-1:0]   rdAddr_q, rdAddr_d;
   logic                    issValid_q, issValid_d;
   logic                    issPad_q, issPad_d;
   logic                    alignValid_q, alignPad_q;
   logic                    en_q;
   logic signed [DATA_WIDTH-1:0] data_q;
   logic                    done_q;

   logic [CW-1:0]           curRow, curCol;
   logic [ADDR_WIDTH-1:0]   issueAddr;
   logic                    posPad, posLast;

   // Position being issued this cycle; a fresh map always starts at (0,0), address 0
   always_comb begin
      curRow    = row_q;
      curCol    = col_q;
      issueAddr = nextAddr_q;
      if (state_q == IDLE) begin
         curRow    = '0;
         curCol    = '0;
         issueAddr = '0;
      end
      posPad  = (int'(curRow) < PADDING) || (int'(curRow) >= PADDING + FM_SIZE) ||
                (int'(curCol) < PADDING) || (int'(curCol) >= PADDING + FM_SIZE);
      posLast = (curRow == LastPos) && (curCol == LastPos);
   end

   // Next-state and issue-stage decode; FLUSH issues the flush slots and then
   // waits two drain cycles so DONE lines up behind the last pixel in flight
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      nextAddr_d = nextAddr_q;
      flushCnt_d = flushCnt_q;
      rdEn_d     = 1'b0;
      rdAddr_d   = rdAddr_q;
      issValid_d = 1'b0;
      issPad_d   = 1'b0;

      if ((state_q == STREAM) || ((state_q == IDLE) && i_start)) begin
         issValid_d = 1'b1;
         issPad_d   = posPad;
         rdEn_d     = !posPad;
         if (!posPad) begin
            rdAddr_d   = issueAddr;
            nextAddr_d = issueAddr + 1'b1;
         end else begin
            nextAddr_d = issueAddr;
         end
         if (posLast) begin
            state_d = FLUSH;
            row_d   = '0;
            col_d   = '0;
         end else begin
            state_d = STREAM;
            if (curCol == LastPos) begin
               col_d = '0;
               row_d = curRow + 1'b1;
            end else begin
               col_d = curCol + 1'b1;
               row_d = curRow;
            end
         end
      end else if (state_q == FLUSH) begin
         if (int'(flushCnt_q) < FLUSH_CYCLES) begin
            issValid_d = 1'b1;
            issPad_d   = 1'b1;
         end
         if (flushCnt_q == FlushEnd) begin
            state_d    = DONE;
            flushCnt_d = '0;
         end else begin
            flushCnt_d = flushCnt_q + 1'b1;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   // FSM, counters and issue-stage registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         nextAddr_q <= '0;
         flushCnt_q <= '0;
         rdEn_q     <= 1'b0;
         rdAddr_q   <= '0;
         issValid_q <= 1'b0;
         issPad_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         nextAddr_q <= nextAddr_d;
         flushCnt_q <= flushCnt_d;
         rdEn_q     <= rdEn_d;
         rdAddr_q   <= rdAddr_d;
         issValid_q <= issValid_d;
         issPad_q   <= issPad_d;
      end
   end

   // Delay valid/pad one cycle to meet the BRAM data, then register the stream
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         alignValid_q <= 1'b0;
         alignPad_q   <= 1'b0;
         en_q         <= 1'b0;
         data_q       <= '0;
      end else begin
         alignValid_q <= issValid_q;
         alignPad_q   <= issPad_q;
         en_q         <= alignValid_q;
         data_q       <= (alignValid_q && !alignPad_q) ? i_rd_data : '0;
      end
   end

   // Done pulse follows the DONE state by one cycle, i.e. right after the last o_en beat
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == DONE);
      end
   end

   assign o_busy    = (state_q != IDLE) || done_q;
   assign o_done    = done_q;
   assign o_rd_en   = rdEn_q;
   assign o_rd_addr = rdAddr_q;
   assign o_en      = en_q;
   assign o_data    = data_q;

endmodule

// File: tb/tb_fm_streamer.sv
// Directed bench for fm_streamer: three instances cover the unpadded 4x4 map,
// the padded 3x3 map and the no-flush 2x2 map, each fed by a small BRAM model.

module tb_fm_streamer;

   logic clk;
   logic rst;
   logic startA, startB, startC;

   logic busyA, doneA, rdEnA, enA;
   logic [3:0] rdAddrA;
   logic signed [29:0] rdDataA, dataA;

   logic busyB, doneB, rdEnB, enB;
   logic [3:0] rdAddrB;
   logic signed [29:0] rdDataB, dataB;

   logic busyC, doneC, rdEnC, enC;
   logic [1:0] rdAddrC;
   logic signed [29:0] rdDataC, dataC;

   logic signed [29:0] memA [16];
   logic signed [29:0] memB [9];
   logic signed [29:0] memC [4];

   int testsRun = 0;
   int testsFailed = 0;

   int outA[$], addrA[$], outB[$], addrB[$], outC[$], addrC[$];
   int doneCntA = 0, doneAfterEnA = 0, runsA = 0;
   int doneCntB = 0, runsB = 0;
   int doneCntC = 0, doneAfterEnC = 0;
   logic prevEnA = 1'b0, prevEnB = 1'b0, prevEnC = 1'b0;

   int expB[27] = '{0,0,0,0,0, 0,1,2,3,0, 0,4,5,6,0, 0,7,8,9,0, 0,0,0,0,0, 0,0};

   fm_streamer #(.FM_SIZE(4), .PADDING(0), .DATA_WIDTH(30), .FLUSH_CYCLES(2)) dutA (
      .i_clk(clk), .i_rst(rst), .i_start(startA), .o_busy(busyA), .o_done(doneA),
      .o_rd_en(rdEnA), .o_rd_addr(rdAddrA), .i_rd_data(rdDataA), .o_en(enA), .o_data(dataA));

   fm_streamer #(.FM_SIZE(3), .PADDING(1), .DATA_WIDTH(30), .FLUSH_CYCLES(2)) dutB (
      .i_clk(clk), .i_rst(rst), .i_start(startB), .o_busy(busyB), .o_done(doneB),
      .o_rd_en(rdEnB), .o_rd_addr(rdAddrB), .i_rd_data(rdDataB), .o_en(enB), .o_data(dataB));

   fm_streamer #(.FM_SIZE(2), .PADDING(0), .DATA_WIDTH(30), .FLUSH_CYCLES(0)) dutC (
      .i_clk(clk), .i_rst(rst), .i_start(startC), .o_busy(busyC), .o_done(doneC),
      .o_rd_en(rdEnC), .o_rd_addr(rdAddrC), .i_rd_data(rdDataC), .o_en(enC), .o_data(dataC));

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read BRAM models
   always @(posedge clk) begin
      if (rdEnA) rdDataA <= memA[rdAddrA];
      if (rdEnB) rdDataB <= memB[rdAddrB];
      if (rdEnC) rdDataC <= memC[rdAddrC];
   end

   // Stream recorders sampling on the falling edge
   always @(negedge clk) begin
      if (enA) outA.push_back(int'(dataA));
      if (rdEnA) addrA.push_back(int'(rdAddrA));
      if (doneA) doneCntA <= doneCntA + 1;
      if (doneA && prevEnA) doneAfterEnA <= doneAfterEnA + 1;
      if (enA && !prevEnA) runsA <= runsA + 1;
      prevEnA <= enA;
      if (enB) outB.push_back(int'(dataB));
      if (rdEnB) addrB.push_back(int'(rdAddrB));
      if (doneB) doneCntB <= doneCntB + 1;
      if (enB && !prevEnB) runsB <= runsB + 1;
      prevEnB <= enB;
      if (enC) outC.push_back(int'(dataC));
      if (rdEnC) addrC.push_back(int'(rdAddrC));
      if (doneC) doneCntC <= doneCntC + 1;
      if (doneC && prevEnC) doneAfterEnC <= doneAfterEnC + 1;
      prevEnC <= enC;
   end

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Raise one start line at a falling edge (0=A, 1=B, 2=C)
   task automatic applyStimulus(input int unit, input logic value);
      @(negedge clk);
      case (unit)
         0: startA = value;
         1: startB = value;
         default: startC = value;
      endcase
   endtask

   function automatic int qAt(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   // Directed test sequence
   initial begin
      int bOut, bAddr, bDone, bRuns, bAfter, gap;
      rst = 1'b0;
      startA = 1'b0;
      startB = 1'b0;
      startC = 1'b0;
      for (int k = 0; k < 16; k++) memA[k] = 30'(k + 1);
      for (int k = 0; k < 9; k++)  memB[k] = 30'(k + 1);
      for (int k = 0; k < 4; k++)  memC[k] = 30'(k + 1);

      // Reset state
      #1 rst = 1'b1;
      #1;
      checkOutput("rst busy", busyA, 0);
      checkOutput("rst done", doneA, 0);
      checkOutput("rst rd_en", rdEnA, 0);
      checkOutput("rst rd_addr", rdAddrA, 0);
      checkOutput("rst en", enA, 0);
      checkOutput("rst data", dataA, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 4x4 unpadded map with two flush slots
      bOut = outA.size(); bAddr = addrA.size(); bDone = doneCntA; bRuns = runsA; bAfter = doneAfterEnA;
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      checkOutput("A E0 rd_en", rdEnA, 1);
      checkOutput("A E0 rd_addr", rdAddrA, 0);
      checkOutput("A E0 en", enA, 0);
      checkOutput("A E0 busy", busyA, 1);
      @(negedge clk);
      checkOutput("A E1 en", enA, 0);
      checkOutput("A E1 rd_addr", rdAddrA, 1);
      @(negedge clk);
      checkOutput("A E2 en", enA, 1);
      checkOutput("A E2 data", dataA, 1);
      for (int i = 0; i < 60 && doneA !== 1'b1; i++) @(negedge clk);
      checkOutput("A done seen", doneA, 1);
      checkOutput("A busy in done", busyA, 1);
      checkOutput("A en in done", enA, 0);
      @(negedge clk);
      checkOutput("A busy after done", busyA, 0);
      checkOutput("A done width", doneA, 0);
      checkOutput("A out count", outA.size() - bOut, 18);
      for (int k = 0; k < 18; k++)
         checkOutput($sformatf("A out[%0d]", k), qAt(outA, bOut + k), (k < 16) ? k + 1 : 0);
      checkOutput("A read count", addrA.size() - bAddr, 16);
      for (int k = 0; k < 16; k++)
         checkOutput($sformatf("A addr[%0d]", k), qAt(addrA, bAddr + k), k);
      checkOutput("A done pulses", doneCntA - bDone, 1);
      checkOutput("A en runs", runsA - bRuns, 1);
      checkOutput("A done after en", doneAfterEnA - bAfter, 1);

      // Signed extremes
      memA[0] = 30'h2000_0000;
      memA[1] = 30'h1FFF_FFFF;
      bOut = outA.size();
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b0);
      for (int i = 0; i < 60 && doneA !== 1'b1; i++) @(negedge clk);
      checkOutput("ext done seen", doneA, 1);
      @(negedge clk);
      checkOutput("ext min", qAt(outA, bOut), -536870912);
      checkOutput("ext max", qAt(outA, bOut + 1), 536870911);
      checkOutput("ext next", qAt(outA, bOut + 2), 3);
      memA[0] = 30'd1;
      memA[1] = 30'd2;

      // Asynchronous reset in mid-stream
      bOut = outA.size(); bDone = doneCntA;
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b0);
      for (int i = 0; i < 40 && (outA.size() - bOut) < 7; i++) @(negedge clk);
      checkOutput("abort reached pixel 7", outA.size() - bOut, 7);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort en", enA, 0);
      checkOutput("abort rd_en", rdEnA, 0);
      checkOutput("abort busy", busyA, 0);
      checkOutput("abort data", dataA, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("abort no done", doneCntA - bDone, 0);
      bOut = outA.size(); bAddr = addrA.size();
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b0);
      for (int i = 0; i < 60 && doneA !== 1'b1; i++) @(negedge clk);
      checkOutput("restart done seen", doneA, 1);
      @(negedge clk);
      checkOutput("restart first addr", qAt(addrA, bAddr), 0);
      checkOutput("restart read count", addrA.size() - bAddr, 16);
      checkOutput("restart out count", outA.size() - bOut, 18);

      // Start held high across the whole run
      bOut = outA.size(); bDone = doneCntA; bRuns = runsA;
      applyStimulus(0, 1'b1);
      for (int i = 0; i < 60 && doneA !== 1'b1; i++) @(negedge clk);
      checkOutput("held done seen", doneA, 1);
      checkOutput("held one map", outA.size() - bOut, 18);
      gap = 0;
      for (int i = 0; i < 10 && enA !== 1'b1; i++) begin
         gap++;
         @(negedge clk);
      end
      checkOutput("held second map", enA, 1);
      checkOutput("held gap <= 3", (gap <= 3), 1);
      startA = 1'b0;
      for (int i = 0; i < 60 && doneA !== 1'b1; i++) @(negedge clk);
      checkOutput("held second done", doneA, 1);
      @(negedge clk);
      checkOutput("held out count", outA.size() - bOut, 36);
      checkOutput("held 2nd first", qAt(outA, bOut + 18), 1);
      checkOutput("held 2nd last pixel", qAt(outA, bOut + 33), 16);
      checkOutput("held done pulses", doneCntA - bDone, 2);
      checkOutput("held en runs", runsA - bRuns, 2);

      // 3x3 map with one pixel of padding
      bOut = outB.size(); bAddr = addrB.size(); bDone = doneCntB; bRuns = runsB;
      applyStimulus(1, 1'b1);
      applyStimulus(1, 1'b0);
      for (int i = 0; i < 80 && doneB !== 1'b1; i++) @(negedge clk);
      checkOutput("B done seen", doneB, 1);
      @(negedge clk);
      checkOutput("B out count", outB.size() - bOut, 27);
      for (int k = 0; k < 27; k++)
         checkOutput($sformatf("B out[%0d]", k), qAt(outB, bOut + k), expB[k]);
      checkOutput("B read count", addrB.size() - bAddr, 9);
      for (int k = 0; k < 9; k++)
         checkOutput($sformatf("B addr[%0d]", k), qAt(addrB, bAddr + k), k);
      checkOutput("B done pulses", doneCntB - bDone, 1);
      checkOutput("B en runs", runsB - bRuns, 1);

      // 2x2 map with no flush slots
      bOut = outC.size(); bDone = doneCntC; bAfter = doneAfterEnC;
      applyStimulus(2, 1'b1);
      applyStimulus(2, 1'b0);
      for (int i = 0; i < 40 && doneC !== 1'b1; i++) @(negedge clk);
      checkOutput("C done seen", doneC, 1);
      @(negedge clk);
      checkOutput("C out count", outC.size() - bOut, 4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("C out[%0d]", k), qAt(outC, bOut + k), k + 1);
      checkOutput("C done pulses", doneCntC - bDone, 1);
      checkOutput("C done after en", doneAfterEnC - bAfter, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
